conv_window_sequencer: RTL and testbench
========================================

// Module: conv_window_sequencer
// PURPOSE
//  Sequences the 2-multiplier/1-adder convolution datapath over a full image, one tap pair per beat.
//  Walks output windows in raster order. For each window it issues KER_ROW*KER_COL/2 beats of
//  image/kernel address pairs, with zero-pad flags and first/last-tap tags.
//  Counts datapath write-backs and signals done when every output pixel has been written.
//  Sits between the top-level control and the image/kernel buffers feeding the multiplier pair.
// PARAMETERS
//  IMG_ROW   128  image rows
//  IMG_COL   128  image columns
//  KER_ROW   8    kernel rows
//  KER_COL   8    kernel columns (KER_ROW*KER_COL must be even)
//  OUT_ROW   32   output rows
//  OUT_COL   32   output columns
//  STRIDE    4    window step in pixels, both axes
// PORTS
//  clk          in   1   single clock, all logic on posedge
//  rst          in   1   synchronous, active-high reset
//  start        in   1   pulse: begin a full-image pass (accepted only in IDLE or DONE)
//  issue_ready  in   1   datapath can accept a beat this cycle
//  wb_valid     in   1   datapath wrote one output pixel this cycle
//  issue_valid  out  1   beat below is valid
//  img_addr0    out  14  image address, tap t   (row*IMG_COL+col)
//  img_addr1    out  14  image address, tap t+1
//  ker_addr0    out  6   kernel address, tap t
//  ker_addr1    out  6   kernel address, tap t+1
//  pad0, pad1   out  1   tap lies outside image: datapath substitutes 0; addr driven 0
//  first_tap    out  1   beat carries taps 0,1 of the window (accumulator clear)
//  last_tap     out  1   beat carries the final two taps of the window
//  out_addr     out  10  output index or*OUT_COL+oc of the window being issued
//  busy         out  1   state is ISSUE or DRAIN
//  done         out  1   sticky; high in DONE until next accepted start or rst
//  err          out  1   sticky; wb_valid seen with wb count already OUT_ROW*OUT_COL, or outside ISSUE/DRAIN
// BEHAVIOUR
//  Reset: state=IDLE; all counters 0; issue_valid, pad*, first_tap, last_tap, busy, done, err = 0;
//   all addresses 0. rst mid-pass aborts at once; no beat is issued in the cycle after rst.
//  FSM IDLE -> ISSUE on start. ISSUE -> DRAIN on the handshake of the last beat of the last window.
//   DRAIN -> DONE when wb count == OUT_ROW*OUT_COL. DONE -> ISSUE on start (clears done, err, counters).
//   start in ISSUE/DRAIN is ignored.
//  Beat = cycle with issue_valid && issue_ready. Counters advance only on a beat.
//   issue_valid stays high and outputs hold stable while issue_ready=0.
//  Outputs are registered: issue_valid rises the cycle after start is accepted (1-cycle latency).
//  Tap index t = 0,2,..,KER_ROW*KER_COL-2; kr=t/KER_COL, kc=t%KER_COL (tap t+1 wraps to next kr if needed).
//  Image coordinates: r=or*STRIDE+kr, c=oc*STRIDE+kc. If r>=IMG_ROW or c>=IMG_COL: padN=1, img_addrN=0.
//  ker_addrN = tap index. first_tap = (t==0); last_tap = (t==KER_ROW*KER_COL-2).
//  Order: t innermost, then oc 0..OUT_COL-1, then or 0..OUT_ROW-1; or/oc wrap to 0 at their limits.
//  Defaults give 32 beats/window and 32768 beats/pass.
//  wb_valid is counted in ISSUE and DRAIN (11-bit count, saturating at 1024). Overflow, or wb_valid
//   in IDLE/DONE, sets err and is not counted.
//  A wb_valid and the last beat in the same cycle are both honoured. If wb count already equals
//   OUT_ROW*OUT_COL at the last beat, the FSM still passes through DRAIN for one cycle.
//  Address arithmetic uses unsigned widths derived with $clog2. Width casts are explicit.
// STRUCTURE
//  Shared package conv_pkg: IMG/KER/OUT dims, STRIDE, derived address widths, tap and pass counts,
//   and the FSM state enum {IDLE, ISSUE, DRAIN, DONE}.
//  One sub-module: conv_tap_addr_gen (combinational: or, oc, t -> img_addr0/1, pad0/1, ker_addr0/1).
//   The sequencer registers its outputs.
// TESTING
//  1 rst then start, issue_ready=1 -> first beat: img_addr0=0, img_addr1=1, ker 0/1, first_tap=1, out_addr=0.
//  2 Beat 32 -> out_addr=1, img_addr0=4, first_tap=1. The beat before it has last_tap=1, img_addr1=7*128+7=903.
//  3 Window or=31, oc=31, taps 0,1 -> r=124, c=124/125, no pad. Window oc=31, kc>=4 taps -> pad=1,
//     img_addr=0 (c>=128). Pad on a final row appears only when kr>=4.
//  4 issue_ready toggled randomly -> beat count 32768, outputs stable whenever stalled;
//     1024 wb_valid pulses -> done high; a 1025th pulse sets err.
//  5 rst asserted at beat 5000 -> next cycle issue_valid=0, busy=0, done=0.
//     Restart reproduces beat 0 exactly.
//  6 start pulsed during ISSUE -> ignored (beat sequence unchanged). start in DONE -> done clears,
//     new pass begins.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared dimensions, derived widths, FSM state and image-tap helper for the conv window sequencer
package conv_pkg;
  localparam int unsigned IMG_ROW = 128;
  localparam int unsigned IMG_COL = 128;
  localparam int unsigned KER_ROW = 8;
  localparam int unsigned KER_COL = 8;
  localparam int unsigned OUT_ROW = 32;
  localparam int unsigned OUT_COL = 32;
  localparam int unsigned STRIDE = 4;
  localparam int unsigned TAPS = KER_ROW * KER_COL;
  localparam int unsigned NPIX = OUT_ROW * OUT_COL;
  localparam int unsigned IMG_AW = $clog2(IMG_ROW * IMG_COL);
  localparam int unsigned KER_AW = $clog2(TAPS);
  localparam int unsigned OUT_AW = $clog2(NPIX);
  localparam int unsigned ROW_W = $clog2(OUT_ROW);
  localparam int unsigned COL_W = $clog2(OUT_COL);
  localparam int unsigned WB_W = $clog2(NPIX + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  typedef struct packed {
    logic pad;
    logic [IMG_AW-1:0] addr;
  } img_tap_t;
  typedef struct packed {
    logic [IMG_AW-1:0] img_addr0;
    logic [IMG_AW-1:0] img_addr1;
    logic [KER_AW-1:0] ker_addr0;
    logic [KER_AW-1:0] ker_addr1;
    logic pad0;
    logic pad1;
    logic first_tap;
    logic last_tap;
    logic [OUT_AW-1:0] out_addr;
  } beat_t;
  function automatic img_tap_t img_tap(input int unsigned row, input int unsigned col, input int unsigned tap);
    img_tap_t res;
    int unsigned r;
    int unsigned c;
    r = row * STRIDE + tap / KER_COL;
    c = col * STRIDE + tap % KER_COL;
    res.pad = r >= IMG_ROW || c >= IMG_COL;
    res.addr = res.pad ? '0 : IMG_AW'(r * IMG_COL + c);
    return res;
  endfunction
endpackage

// File: rtl/conv_tap_addr_gen.sv
// conv_tap_addr_gen: maps window (row, col) and even tap index to the image/kernel address pair with pad flags
module conv_tap_addr_gen
  import conv_pkg::*;
(
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  input  logic [KER_AW-1:0] tap,
  output logic [IMG_AW-1:0] img_addr0,
  output logic [IMG_AW-1:0] img_addr1,
  output logic [KER_AW-1:0] ker_addr0,
  output logic [KER_AW-1:0] ker_addr1,
  output logic              pad0,
  output logic              pad1
);
  img_tap_t t0, t1;
  always_comb begin
    t0 = img_tap(32'(row), 32'(col), 32'(tap));
    t1 = img_tap(32'(row), 32'(col), 32'(tap) + 32'd1);
    img_addr0 = t0.addr;
    img_addr1 = t1.addr;
    pad0 = t0.pad;
    pad1 = t1.pad;
    ker_addr0 = tap;
    ker_addr1 = tap + KER_AW'(1);
  end
endmodule

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: raster-order window walker issuing registered tap-pair beats and counting write-backs
module conv_window_sequencer
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              issue_ready,
  input  logic              wb_valid,
  output logic              issue_valid,
  output logic [IMG_AW-1:0] img_addr0,
  output logic [IMG_AW-1:0] img_addr1,
  output logic [KER_AW-1:0] ker_addr0,
  output logic [KER_AW-1:0] ker_addr1,
  output logic              pad0,
  output logic              pad1,
  output logic              first_tap,
  output logic              last_tap,
  output logic [OUT_AW-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [KER_AW-1:0] tap_q, tap_d;
  logic [WB_W-1:0] wb_q, wb_d;
  logic valid_q, valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  beat_t beat_q, beat_d;
  logic go, beat, win_end, col_end, row_end, wb_take;
  logic [IMG_AW-1:0] g_img0, g_img1;
  logic [KER_AW-1:0] g_ker0, g_ker1;
  logic g_pad0, g_pad1;
  conv_tap_addr_gen u_gen (
    .row(row_d), .col(col_d), .tap(tap_d),
    .img_addr0(g_img0), .img_addr1(g_img1),
    .ker_addr0(g_ker0), .ker_addr1(g_ker1),
    .pad0(g_pad0), .pad1(g_pad1)
  );
  always_comb begin
    go = start && (state_q == IDLE || state_q == DONE);
    beat = valid_q && issue_ready;
    win_end = tap_q == KER_AW'(TAPS - 2);
    col_end = col_q == COL_W'(OUT_COL - 1);
    row_end = row_q == ROW_W'(OUT_ROW - 1);
    tap_d = go ? '0 : !beat ? tap_q : win_end ? '0 : tap_q + KER_AW'(2);
    col_d = go ? '0 : !(beat && win_end) ? col_q : col_end ? '0 : col_q + COL_W'(1);
    row_d = go ? '0 : !(beat && win_end && col_end) ? row_q : row_end ? '0 : row_q + ROW_W'(1);
    state_d = go ? ISSUE
      : (state_q == ISSUE && beat && win_end && col_end && row_end) ? DRAIN
      : (state_q == DRAIN && wb_q == WB_W'(NPIX)) ? DONE
      : state_q;
    wb_take = wb_valid && (state_q == ISSUE || state_q == DRAIN) && wb_q != WB_W'(NPIX);
    wb_d = go ? '0 : wb_q + WB_W'(wb_take);
    err_d = (err_q && !go) || (wb_valid && !wb_take);
    valid_d = state_d == ISSUE;
    busy_d = state_d == ISSUE || state_d == DRAIN;
    done_d = state_d == DONE;
  end
  always_comb begin
    beat_d = valid_d ? beat_t'{
      img_addr0: g_img0,
      img_addr1: g_img1,
      ker_addr0: g_ker0,
      ker_addr1: g_ker1,
      pad0: g_pad0,
      pad1: g_pad1,
      first_tap: tap_d == '0,
      last_tap: tap_d == KER_AW'(TAPS - 2),
      out_addr: OUT_AW'(32'(row_d) * OUT_COL + 32'(col_d))
    } : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      tap_q <= '0;
      wb_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      beat_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      tap_q <= tap_d;
      wb_q <= wb_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      beat_q <= beat_d;
    end
  end
  assign issue_valid = valid_q;
  assign img_addr0 = beat_q.img_addr0;
  assign img_addr1 = beat_q.img_addr1;
  assign ker_addr0 = beat_q.ker_addr0;
  assign ker_addr1 = beat_q.ker_addr1;
  assign pad0 = beat_q.pad0;
  assign pad1 = beat_q.pad1;
  assign first_tap = beat_q.first_tap;
  assign last_tap = beat_q.last_tap;
  assign out_addr = beat_q.out_addr;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer: scoreboard bench for the conv window sequencer
module tb_conv_window_sequencer;
  localparam int PASS = 32768;
  typedef struct packed {
    logic [13:0] a0;
    logic [13:0] a1;
    logic [5:0] k0;
    logic [5:0] k1;
    logic p0;
    logic p1;
    logic ft;
    logic lt;
    logic [9:0] oa;
  } exp_t;
  logic clk = 1'b0;
  logic rst, start, issue_ready, wb_valid;
  logic issue_valid, pad0, pad1, first_tap, last_tap, busy, done, err;
  logic [13:0] img_addr0, img_addr1;
  logic [5:0] ker_addr0, ker_addr1;
  logic [9:0] out_addr;
  exp_t sb[$];
  int checks = 0;
  int fails = 0;
  int n = 0;
  int cyc = 0;
  int wb_sent = 0;
  int wb2 = 0;
  logic rdy, wbv;
  always #5 clk = ~clk;
  conv_window_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .issue_ready(issue_ready), .wb_valid(wb_valid),
    .issue_valid(issue_valid), .img_addr0(img_addr0), .img_addr1(img_addr1),
    .ker_addr0(ker_addr0), .ker_addr1(ker_addr1), .pad0(pad0), .pad1(pad1),
    .first_tap(first_tap), .last_tap(last_tap), .out_addr(out_addr),
    .busy(busy), .done(done), .err(err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input int b);
    exp_t e;
    int win, t, row, col, r, c;
    win = b / 32;
    t = (b % 32) * 2;
    row = win / 32;
    col = win % 32;
    r = row * 4 + t / 8;
    c = col * 4 + t % 8;
    e.p0 = (r > 127 || c > 127);
    e.a0 = e.p0 ? 14'd0 : 14'(r * 128 + c);
    r = row * 4 + (t + 1) / 8;
    c = col * 4 + (t + 1) % 8;
    e.p1 = (r > 127 || c > 127);
    e.a1 = e.p1 ? 14'd0 : 14'(r * 128 + c);
    e.k0 = 6'(t);
    e.k1 = 6'(t + 1);
    e.ft = (t == 0);
    e.lt = (t == 62);
    e.oa = 10'(win);
    return e;
  endfunction
  task automatic push_pass();
    sb.delete();
    for (int i = 0; i < PASS; i++) sb.push_back(model(i));
  endtask
  task automatic spot(input exp_t g);
    if (n == 0) begin
      check("b0_addr0", 64'(g.a0), 64'd0);
      check("b0_addr1", 64'(g.a1), 64'd1);
      check("b0_first", 64'(g.ft), 64'd1);
      check("b0_out", 64'(g.oa), 64'd0);
    end
    if (n == 31) begin
      check("b31_last", 64'(g.lt), 64'd1);
      check("b31_addr1", 64'(g.a1), 64'd903);
    end
    if (n == 32) begin
      check("b32_out", 64'(g.oa), 64'd1);
      check("b32_addr0", 64'(g.a0), 64'd4);
      check("b32_first", 64'(g.ft), 64'd1);
    end
    if (n == 32736) begin
      check("w1023_a0", 64'(g.a0), 64'd15996);
      check("w1023_a1", 64'(g.a1), 64'd15997);
      check("w1023_pad", 64'({g.p0, g.p1}), 64'd0);
    end
    if (n == 32738) begin
      check("w1023_kc4_pad", 64'({g.p0, g.p1}), 64'd3);
      check("w1023_kc4_addr", 64'(g.a0), 64'd0);
    end
    if (n == 31744 + 15) begin
      check("lastrow_kr3_pad", 64'({g.p0, g.p1}), 64'd0);
      check("lastrow_kr3_a0", 64'(g.a0), 64'd16262);
    end
    if (n == 31744 + 16) check("lastrow_kr4_pad", 64'({g.p0, g.p1}), 64'd3);
  endtask
  task automatic step(input logic r, input logic w);
    exp_t g;
    exp_t e;
    issue_ready = r;
    wb_valid = w;
    g = {img_addr0, img_addr1, ker_addr0, ker_addr1, pad0, pad1, first_tap, last_tap, out_addr};
    if (issue_valid) begin
      e = sb.size() > 0 ? sb[0] : '1;
      check("beat", 64'(g), 64'(e));
      if (r) begin
        if (sb.size() > 0) void'(sb.pop_front());
        spot(g);
        n++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    issue_ready = 1'b0;
    wb_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(issue_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_addr", 64'({img_addr0, out_addr, first_tap}), 64'd0);
    rst = 1'b0;
    push_pass();
    n = 0;
    start = 1'b1;
    step(1'b1, 1'b0);
    start = 1'b0;
    check("start_latency", 64'(issue_valid), 64'd1);
    check("start_busy", 64'(busy), 64'd1);
    while (n < PASS && cyc < 60000) begin
      start = (n == 100);
      rdy = $urandom_range(0, 3) != 0;
      wbv = (wb_sent < 1024) && ($urandom_range(0, 39) == 0);
      step(rdy, wbv);
      wb_sent += int'(wbv);
    end
    start = 1'b0;
    check("pass1_beats", 64'(n), 64'(PASS));
    check("pass1_sb_left", 64'(sb.size()), 64'd0);
    check("drain_valid", 64'(issue_valid), 64'd0);
    if (wb_sent < 1024) check("drain_done", 64'({busy, done}), 64'b10);
    while (wb_sent < 1024 && cyc < 62000) begin
      step(1'b0, 1'b1);
      wb_sent++;
    end
    for (int k = 0; k < 10 && !done; k++) step(1'b0, 1'b0);
    check("pass1_done", 64'(done), 64'd1);
    check("pass1_busy", 64'(busy), 64'd0);
    check("pass1_err", 64'(err), 64'd0);
    step(1'b0, 1'b1);
    check("extra_wb_err", 64'(err), 64'd1);
    check("extra_wb_done", 64'(done), 64'd1);
    push_pass();
    n = 0;
    start = 1'b1;
    step(1'b1, 1'b0);
    start = 1'b0;
    check("restart_done", 64'(done), 64'd0);
    check("restart_err", 64'(err), 64'd0);
    check("restart_valid", 64'(issue_valid), 64'd1);
    while (n < 5000 && cyc < 70000) begin
      wbv = wb2 < 1025;
      step(1'b1, wbv);
      if (wbv) begin
        wb2++;
        if (wb2 == 1024) check("wb1024_err", 64'(err), 64'd0);
        if (wb2 == 1025) check("wb1025_err", 64'(err), 64'd1);
      end
    end
    check("pass2_beats", 64'(n), 64'd5000);
    rst = 1'b1;
    issue_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_valid", 64'(issue_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    step(1'b1, 1'b0);
    check("idle_after_rst", 64'(issue_valid), 64'd0);
    push_pass();
    n = 0;
    start = 1'b1;
    step(1'b1, 1'b0);
    start = 1'b0;
    while (n < 64 && cyc < 72000) step($urandom_range(0, 1) != 0, 1'b0);
    check("restart_beats", 64'(n), 64'd64);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
